// File: rtl/tdes_pkg.sv
// rtl/tdes_pkg.sv - shared state encodings, block geometry and byte-lane helper for tdes_stream_buf
package tdes_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int BLOCK_BYTES = 8;
    localparam int BLOCK_W     = 64;

    // Byte 0 sits in the most significant lane, byte 7 in the least.
    function automatic logic [5:0] lane_lsb(input logic [2:0] idx);
        return {~idx, 3'b000};
    endfunction

endpackage

// File: rtl/tdes_byte_unpack.sv
// rtl/tdes_byte_unpack.sv - 64-bit block to byte stream serializer, most significant byte first
module tdes_byte_unpack
    import tdes_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [BLOCK_W-1:0] load_data,
    output logic               m_valid,
    output logic [7:0]         m_data,
    input  logic               m_ready,
    output logic               last
);

    logic [BLOCK_W-1:0] data_q;
    logic [2:0]         idx_q;
    logic               valid_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            idx_q   <= 3'd0;
            valid_q <= 1'b0;
        end else if (load) begin
            data_q  <= load_data;
            idx_q   <= 3'd0;
            valid_q <= 1'b1;
        end else if (valid_q && m_ready) begin
            // Index wraps back to 0 after the eighth byte, ready for the next block.
            idx_q <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign m_valid = valid_q;
    assign m_data  = data_q[lane_lsb(idx_q) +: 8];
    assign last    = valid_q && m_ready && (idx_q == 3'd7);

endmodule

// File: rtl/tdes_stream_buf.sv
// rtl/tdes_stream_buf.sv - byte stream to TDES core block buffer; TDES_BUF_TIMEOUT_EN enables the core wait timeout
module tdes_stream_buf
    import tdes_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mode_i,
    input  logic               s_valid,
    input  logic [7:0]         s_data,
    output logic               s_ready,
    output logic               m_valid,
    output logic [7:0]         m_data,
    input  logic               m_ready,
    output logic               core_ready,
    output logic               core_mode,
    output logic [BLOCK_W-1:0] core_data,
    input  logic               core_ok,
    input  logic [BLOCK_W-1:0] core_result,
    output logic               busy,
    output logic               timeout_err
);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t             state_q, state_d;
    logic [2:0]         fill_cnt;
    logic [BLOCK_W-1:0] core_data_q;
    logic               core_mode_q;
    logic               rdy_en_q;
    logic               accept;
    logic               load;
    logic               last;
    logic               abort;

    // rdy_en_q keeps s_ready low until the first edge after reset release.
    assign s_ready    = rdy_en_q && (state_q == FILL);
    assign accept     = s_valid && s_ready;
    assign load       = (state_q == WAIT) && core_ok;
    assign core_ready = (state_q == START);
    assign busy       = (state_q != FILL);
    assign core_data  = core_data_q;
    assign core_mode  = core_mode_q;

`ifdef TDES_BUF_TIMEOUT_EN
    localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_q;

    assign abort       = (state_q == WAIT) && !core_ok && (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err = timeout_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (abort) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    assign abort       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL:  if (accept && (fill_cnt == 3'd7)) state_d = START;
            START: state_d = WAIT;
            WAIT: begin
                if (core_ok) begin
                    state_d = DRAIN;
                end else if (abort) begin
                    state_d = FILL;
                end
            end
            DRAIN: if (last) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_cnt    <= 3'd0;
            core_data_q <= '0;
            core_mode_q <= 1'b0;
            rdy_en_q    <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            if (accept) begin
                core_data_q[lane_lsb(fill_cnt) +: 8] <= s_data;
                if (fill_cnt == 3'd0) begin
                    core_mode_q <= mode_i;
                end
                fill_cnt <= fill_cnt + 3'd1;
            end
        end
    end

    tdes_byte_unpack u_unpack (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_data (core_result),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .last      (last)
    );

endmodule

// File: tb/tb_tdes_stream_buf.sv
// tb/tb_tdes_stream_buf.sv - scoreboard bench for tdes_stream_buf with a behavioural TDES core model
module tb_tdes_stream_buf;

    typedef struct {
        logic        mode;
        logic [63:0] data;
    } blk_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mode_i = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_ready;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_ready = 1'b1;
    logic        core_ready;
    logic        core_mode;
    logic [63:0] core_data;
    logic        core_ok = 1'b0;
    logic [63:0] core_result = 64'h0;
    logic        busy;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int epoch = 0;
    int fixed_lat = 0;
    int m_ready_mode = 0;
    bit use_fixed_res = 0;
    bit core_mute = 0;
    bit core_active = 0;
    bit chk_after = 0;
    bit mon_en = 0;
    logic [63:0] fixed_res = 64'h0;

    blk_t       exp_core_q[$];
    blk_t       core_pend_q[$];
    logic [7:0] exp_byte_q[$];

    tdes_stream_buf #(.TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .mode_i      (mode_i),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_ready     (m_ready),
        .core_ready  (core_ready),
        .core_mode   (core_mode),
        .core_data   (core_data),
        .core_ok     (core_ok),
        .core_result (core_result),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event occurred, expected none", name);
    endtask

    always @(posedge clk) begin
        #1;
        case (m_ready_mode)
            0: m_ready = 1'b1;
            1: m_ready = ~m_ready;
            default: m_ready = 1'($urandom);
        endcase
    end

    // Monitor: compares every DUT presentation against the scoreboard heads.
    always @(negedge clk) begin
        blk_t b;
        if (mon_en) begin
            if (chk_after) begin
                check("m_valid_low_after_drain", m_valid, 0);
                check("s_ready_after_drain", s_ready, 1);
                chk_after = 0;
            end
            if (core_ready) begin
                if (exp_core_q.size() == 0) begin
                    fail("core_ready_unexpected");
                end else begin
                    b = exp_core_q.pop_front();
                    check("core_data", core_data, b.data);
                    check("core_mode", core_mode, b.mode);
                    check("core_ready_latency", cyc, accept_cyc);
                    core_pend_q.push_back(b);
                end
            end
            if (m_valid) begin
                if (exp_byte_q.size() == 0) begin
                    fail("m_valid_unexpected");
                end else begin
                    check("m_data", m_data, exp_byte_q[0]);
                    if (m_ready) begin
                        void'(exp_byte_q.pop_front());
                        if (exp_byte_q.size() == 0) chk_after = 1;
                    end
                end
            end
        end
    end

    // TDES core model: answers each started block with a result after a latency.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (core_pend_q.size() > 0) begin
                blk_t        b;
                int          ep;
                int          lat;
                logic [63:0] res;
                b = core_pend_q.pop_front();
                if (!core_mute) begin
                    ep = epoch;
                    core_active = 1;
                    lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 20));
                    for (int k = 1; k < lat; k++) begin
                        @(posedge clk);
                        #1;
                        if (ep != epoch) break;
                    end
                    if (ep == epoch) begin
                        res = use_fixed_res ? fixed_res : {$urandom, $urandom};
                        check("core_data_hold", core_data, b.data);
                        check("core_mode_hold", core_mode, b.mode);
                        for (int i = 0; i < 8; i++) exp_byte_q.push_back(res[63-8*i -: 8]);
                        core_ok = 1'b1;
                        core_result = res;
                        @(posedge clk);
                        #1;
                        core_ok = 1'b0;
                        core_result = {$urandom, $urandom};
                    end
                    core_active = 0;
                end
            end
        end
    end

    task automatic send_bytes(input logic [63:0] data, input logic mode, input int nbytes, input bit gaps);
        for (int i = 0; i < nbytes; i++) begin
            int n;
            bit acc;
            s_valid = 1'b1;
            s_data  = data[63-8*i -: 8];
            mode_i  = (i == 0) ? mode : 1'($urandom);
            n = 0;
            forever begin
                @(negedge clk);
                acc = s_ready;
                @(posedge clk);
                #1;
                if (acc) break;
                n++;
                if (n > 600) begin
                    fail("s_ready_timeout");
                    break;
                end
            end
            s_valid = 1'b0;
            s_data  = 8'($urandom);
            if (i == 7) begin
                accept_cyc = cyc;
                exp_core_q.push_back('{mode, data});
            end
            if (gaps) repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (exp_core_q.size() == 0 && exp_byte_q.size() == 0 && core_pend_q.size() == 0
                && !core_active && !busy) break;
            n++;
            if (n > 3000) begin
                fail(name);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        mon_en = 0;
        s_valid = 1'b0;
        core_ok = 1'b0;
        reset = 1'b0;
        epoch++;
        exp_core_q.delete();
        core_pend_q.delete();
        exp_byte_q.delete();
        chk_after = 0;
        #1;
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_core_ready", core_ready, 0);
        check("rst_core_data", core_data, 0);
        check("rst_core_mode", core_mode, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout_err", timeout_err, 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(negedge clk);
        check("s_ready_before_first_edge", s_ready, 0);
        @(posedge clk);
        #1;
        check("s_ready_after_release", s_ready, 1);
        mon_en = 1;
    endtask

    initial begin
        int n;
        #2;
        do_reset();

        // Known block, known result, fixed latency, m_ready held high.
        fixed_lat = 20;
        use_fixed_res = 1;
        fixed_res = 64'hA1A2A3A4A5A6A7A8;
        m_ready_mode = 0;
        send_bytes(64'h0102030405060708, 1'b0, 8, 0);
        wait_idle("idle_basic");

        // Decrypt block drained with m_ready toggling every cycle.
        m_ready_mode = 1;
        use_fixed_res = 0;
        send_bytes({$urandom, $urandom}, 1'b1, 8, 0);
        wait_idle("idle_toggle");

        // Reset after five bytes, then a fresh block.
        m_ready_mode = 0;
        send_bytes(64'h5152535455565758, 1'b1, 5, 0);
        do_reset();
        send_bytes(64'h1112131415161718, 1'b0, 8, 0);
        wait_idle("idle_after_reset");

        // Reset while draining: no byte may follow the release.
        m_ready_mode = 2;
        send_bytes({$urandom, $urandom}, 1'b1, 8, 0);
        n = 0;
        while (!m_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_reached", m_valid, 1);
        @(posedge clk);
        #1;
        do_reset();
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        check("no_output_after_reset", m_valid, 0);

        // Randomized back-to-back traffic.
        fixed_lat = 0;
        for (int b = 0; b < 12; b++) begin
            send_bytes({$urandom, $urandom}, 1'($urandom), 8, 1);
        end
        wait_idle("idle_random");

        // A core_ok pulse outside WAIT must be ignored.
        core_result = {$urandom, $urandom};
        core_ok = 1'b1;
        @(posedge clk);
        #1;
        core_ok = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stray_ok_m_valid", m_valid, 0);
            check("stray_ok_busy", busy, 0);
        end
        @(posedge clk);
        #1;

`ifdef TDES_BUF_TIMEOUT_EN
        core_mute = 1;
        send_bytes({$urandom, $urandom}, 1'b0, 8, 0);
        n = 0;
        forever begin
            @(negedge clk);
            if (!busy || n > 100) break;
            n++;
        end
        check("timeout_busy_cycles", n, 17);
        check("timeout_err_set", timeout_err, 1);
        core_mute = 0;
        @(posedge clk);
        #1;
        core_ok = 1'b1;
        @(posedge clk);
        #1;
        core_ok = 1'b0;
        repeat (5) @(negedge clk);
        check("timeout_no_m_valid", m_valid, 0);
        send_bytes({$urandom, $urandom}, 1'b1, 8, 0);
        wait_idle("idle_after_timeout");
        check("timeout_err_sticky", timeout_err, 1);
`else
        check("timeout_err_tied_low", timeout_err, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tdes_stream_buf.md
TDES_STREAM_BUF -- requirements
Module: tdes_stream_buf

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max WAIT-state cycles before abort (used only with TDES_BUF_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 mode_i  input  1  block direction: 1=decrypt, 0=encrypt; sampled with first byte of each block.
REQ-005 s_valid / s_data / s_ready  input 1 / input 8 / output 1  byte input stream, valid/ready handshake.
REQ-006 m_valid / m_data / m_ready  output 1 / output 8 / input 1  byte output stream, valid/ready handshake.
REQ-007 core_ready  output  1  one-cycle start strobe to the TDES core.
REQ-008 core_mode  output  1  direction to the TDES core.
REQ-009 core_data  output  64  block to the TDES core, bit 1 = MSB.
REQ-010 core_ok  input  1  TDES core result-valid pulse.
REQ-011 core_result  input  64  TDES core result, valid while core_ok=1.
REQ-012 busy  output  1  high in any state except FILL.
REQ-013 timeout_err  output  1  sticky core-timeout flag.

Function
REQ-014 States SHALL be FILL, START, WAIT, DRAIN; next-state logic combinational, state register clocked.
REQ-015 FILL: s_ready=1; byte accepted on s_valid&s_ready; first accepted byte -> core_data[1:8], eighth -> [57:64]; 3-bit counter 0..7.
REQ-016 mode_i SHALL be latched into core_mode on acceptance of byte 0 and held until the block leaves DRAIN or is aborted.
REQ-017 Acceptance of byte 7 at cycle T SHALL enter START at T+1; s_ready=0 from T+1 until return to FILL.
REQ-018 START: core_ready=1 for exactly one cycle, then WAIT; core_ready=0 in every other state.
REQ-019 core_data and core_mode SHALL remain stable from START through WAIT.
REQ-020 WAIT: core_ok=1 SHALL capture core_result into the output register and enter DRAIN next cycle.
REQ-021 core_ok in any state other than WAIT SHALL be ignored.
REQ-022 DRAIN: m_valid=1, m_data = output byte at index (order [1:8] first); index advances on m_valid&m_ready; after byte 7 transfers, return to FILL with counters at 0.
REQ-023 m_data SHALL be held stable while m_valid=1 and m_ready=0.
REQ-024 FILL SHALL not accept bytes in the same cycle DRAIN transfers its last byte (accepting resumes next cycle).

Reset
REQ-025 reset low SHALL immediately force state=FILL, counters=0, core_data=0, output register=0, core_mode=0, s_ready=0 while reset asserted, m_valid=0, core_ready=0, busy=0, timeout_err=0.
REQ-026 Reset mid-block (any state) SHALL discard partial input and pending output; no byte emitted after release.
REQ-027 s_ready SHALL go high the first clock edge after reset deassertion.

Configuration
REQ-028 With TDES_BUF_TIMEOUT_EN defined: WAIT counter increments each WAIT cycle; on reaching TIMEOUT_CYCLES without core_ok, block discarded, timeout_err set (cleared only by reset), return to FILL.
REQ-029 Without TDES_BUF_TIMEOUT_EN: WAIT persists until core_ok; timeout_err tied to 0; no counter logic.

Structure
REQ-030 Shared package tdes_pkg SHALL hold state encodings (FILL=2'd0, START=2'd1, WAIT=2'd2, DRAIN=2'd3), BLOCK_BYTES=8, BLOCK_W=64.
REQ-031 Output serializer SHALL be one sub-module tdes_byte_unpack (64-bit load, 8-bit valid/ready out); packing stays in top.

Verification
REQ-032 Bytes 01..08, mode_i=0 -> core_data=0x0102030405060708, core_mode=0, one core_ready pulse one cycle after byte 08 accepted.
REQ-033 Core model returns 0xA1A2A3A4A5A6A7A8 20 cycles later -> m_data A1..A8 in order, m_valid low afterward, s_ready high next cycle.
REQ-034 m_ready toggled 1/0 each cycle during DRAIN -> eight transfers, m_data stable on stalled cycles, no loss/duplication.
REQ-035 Reset asserted after 5 bytes accepted -> all outputs at reset values; subsequent bytes 11..18 produce core_data=0x1112131415161718.
REQ-036 TDES_BUF_TIMEOUT_EN, TIMEOUT_CYCLES=16, core_ok never asserted -> timeout_err=1 after 16 WAIT cycles, FILL re-entered, no m_valid; core_ok pulse in FILL ignored.
